// File: rtl/ahb_io_slave.sv
// rtl/ahb_io_slave.sv - zero-wait-state AHB-Lite board I/O slave (switches, LEDs, RGB, 8-digit hex display)
module ahb_io_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   input  logic [15:0]           SW,
   output logic [15:0]           LED,
   output logic [5:0]            RGB,
   output logic [15:0]           D_7SEG,
   output logic [7:0]            EN_7SEG
);

   localparam int              DIV_W    = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   // Word offsets within the 32-byte window
   localparam logic [2:0] OFF_SW       = 3'd0;
   localparam logic [2:0] OFF_LED      = 3'd1;
   localparam logic [2:0] OFF_RGB      = 3'd2;
   localparam logic [2:0] OFF_SEG_VAL  = 3'd3;
   localparam logic [2:0] OFF_SEG_CTRL = 3'd4;
   localparam logic [2:0] OFF_CYCLES   = 3'd5;

   // Data-phase context captured from the accepted address phase
   logic        dp_valid_q, dp_valid_d;
   logic        dp_write_q, dp_write_d;
   logic [2:0]  dp_off_q,   dp_off_d;
   logic [1:0]  dp_lo_q,    dp_lo_d;
   logic [2:0]  dp_size_q,  dp_size_d;

   // Architectural registers
   logic [15:0] led_q,      led_d;
   logic [5:0]  rgb_q,      rgb_d;
   logic [31:0] seg_val_q,  seg_val_d;
   logic [15:0] seg_ctrl_q, seg_ctrl_d;
   logic [31:0] cycles_q,   cycles_d;

   // Switch synchroniser
   logic [15:0] sw_meta_q,  sw_meta_d;
   logic [15:0] sw_sync_q,  sw_sync_d;

   // Display scan state and registered pin drivers
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       en_q,  en_d;
   logic [7:0]       seg_q, seg_d;

   // Write-path helpers
   logic        accept;
   logic        wr_en;
   logic [3:0]  lanes;
   logic [31:0] wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;

   // Only HADDR[4:2]/[1:0] and HTRANS[1] carry meaning here
   logic unused_bits;
   assign unused_bits = ^{HADDR[ADDR_WIDTH-1:5], HTRANS[0]};

   // Active-low hex font for segments G..A
   function automatic logic [6:0] hexseg(input logic [3:0] v);
      case (v)
         4'h0:    hexseg = 7'h40;
         4'h1:    hexseg = 7'h79;
         4'h2:    hexseg = 7'h24;
         4'h3:    hexseg = 7'h30;
         4'h4:    hexseg = 7'h19;
         4'h5:    hexseg = 7'h12;
         4'h6:    hexseg = 7'h02;
         4'h7:    hexseg = 7'h78;
         4'h8:    hexseg = 7'h00;
         4'h9:    hexseg = 7'h10;
         4'hA:    hexseg = 7'h08;
         4'hB:    hexseg = 7'h03;
         4'hC:    hexseg = 7'h46;
         4'hD:    hexseg = 7'h21;
         4'hE:    hexseg = 7'h06;
         default: hexseg = 7'h0E;
      endcase
   endfunction

   // Slave never stalls and never errors
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   assign LED     = led_q;
   assign RGB     = rgb_q;
   assign EN_7SEG = en_q;
   assign D_7SEG  = {seg_q, seg_q};
   assign HRDATA  = rdata;

   // Address-phase capture; a non-accepted phase drops the data-phase flag
   always_comb begin
      accept     = HSEL & HREADY & HTRANS[1];
      dp_valid_d = accept;
      dp_write_d = dp_write_q;
      dp_off_d   = dp_off_q;
      dp_lo_d    = dp_lo_q;
      dp_size_d  = dp_size_q;
      if (accept) begin
         dp_write_d = HWRITE;
         dp_off_d   = HADDR[4:2];
         dp_lo_d    = HADDR[1:0];
         dp_size_d  = HSIZE;
      end
   end

   // Byte-lane enables from the latched size/low address bits
   always_comb begin
      lanes = 4'b1111;
      case (dp_size_q)
         3'd0:    lanes = 4'b0001 << dp_lo_q;
         3'd1:    lanes = dp_lo_q[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
      wmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      wdata = HWDATA;
      wr_en = dp_valid_q & dp_write_q;
   end

   // Register file next state: lane-merged writes, free-running cycle counter
   always_comb begin
      led_d      = led_q;
      rgb_d      = rgb_q;
      seg_val_d  = seg_val_q;
      seg_ctrl_d = seg_ctrl_q;
      cycles_d   = cycles_q + 32'd1;
      if (wr_en) begin
         case (dp_off_q)
            OFF_LED:      led_d      = (led_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
            OFF_RGB:      rgb_d      = (rgb_q & ~wmask[5:0]) | (wdata[5:0] & wmask[5:0]);
            OFF_SEG_VAL:  seg_val_d  = (seg_val_q & ~wmask) | (wdata & wmask);
            OFF_SEG_CTRL: seg_ctrl_d = (seg_ctrl_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
            default:      ;
         endcase
      end
   end

   // Read mux, driven only during a read data phase
   always_comb begin
      rdata = 32'd0;
      if (dp_valid_q && !dp_write_q) begin
         case (dp_off_q)
            OFF_SW:       rdata = {16'd0, sw_sync_q};
            OFF_LED:      rdata = {16'd0, led_q};
            OFF_RGB:      rdata = {26'd0, rgb_q};
            OFF_SEG_VAL:  rdata = seg_val_q;
            OFF_SEG_CTRL: rdata = {16'd0, seg_ctrl_q};
            OFF_CYCLES:   rdata = cycles_q;
            default:      rdata = 32'd0;
         endcase
      end
   end

   // Two-stage switch synchroniser
   always_comb begin
      sw_meta_d = SW;
      sw_sync_d = sw_meta_q;
   end

   // Display scan: digit index advances every REFRESH_DIV cycles regardless of enables
   always_comb begin
      logic [3:0] nib;
      logic [7:0] dp_en;
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = idx_q + 3'd1;
      end
      nib   = seg_val_q[{idx_q, 2'b00} +: 4];
      dp_en = seg_ctrl_q[15:8];
      en_d  = ~((8'b0000_0001 << idx_q) & seg_ctrl_q[7:0]);
      seg_d = {~dp_en[idx_q], hexseg(nib)};
   end

   // State register; reset also discards any pending write data phase
   always_ff @(posedge CLK) begin
      if (RST) begin
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_off_q   <= 3'd0;
         dp_lo_q    <= 2'd0;
         dp_size_q  <= 3'd0;
         led_q      <= 16'd0;
         rgb_q      <= 6'd0;
         seg_val_q  <= 32'd0;
         seg_ctrl_q <= 16'h00FF;
         cycles_q   <= 32'd0;
         sw_meta_q  <= 16'd0;
         sw_sync_q  <= 16'd0;
         div_q      <= '0;
         idx_q      <= 3'd0;
         en_q       <= 8'hFF;
         seg_q      <= 8'hFF;
      end else begin
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_off_q   <= dp_off_d;
         dp_lo_q    <= dp_lo_d;
         dp_size_q  <= dp_size_d;
         led_q      <= led_d;
         rgb_q      <= rgb_d;
         seg_val_q  <= seg_val_d;
         seg_ctrl_q <= seg_ctrl_d;
         cycles_q   <= cycles_d;
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
         en_q       <= en_d;
         seg_q      <= seg_d;
      end
   end

endmodule

// File: tb/tb_ahb_io_slave.sv
// tb/tb_ahb_io_slave.sv - self-checking bench for ahb_io_slave
module tb_ahb_io_slave;

   localparam int RDIV = 4;

   logic        clk;
   logic        rst;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;
   logic [15:0] sw;
   logic [15:0] led;
   logic [5:0]  rgb;
   logic [15:0] d7;
   logic [7:0]  en7;

   int checks;
   int errors;

   // Behavioural model state
   logic [15:0] m_led;
   logic [5:0]  m_rgb;
   logic [31:0] m_segv;
   logic [15:0] m_segc;
   logic [31:0] mcyc;
   logic [6:0]  hex_tab [16];

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[$];

   ahb_io_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REFRESH_DIV(RDIV)) dut (
      .CLK(clk), .RST(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp), .SW(sw),
      .LED(led), .RGB(rgb), .D_7SEG(d7), .EN_7SEG(en7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release: mirrors what CYCLES must hold
   always @(posedge clk) begin
      if (rst) mcyc <= 32'd0;
      else     mcyc <= mcyc + 32'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a[4:2])
         3'd0:    return {16'd0, sw};
         3'd1:    return {16'd0, m_led};
         3'd2:    return {26'd0, m_rgb};
         3'd3:    return m_segv;
         3'd4:    return {16'd0, m_segc};
         3'd5:    return mcyc;
         default: return 32'd0;
      endcase
   endfunction

   // Write modelled as "bytes inside the naturally aligned size window"
   function automatic void model_write(input logic [4:0] a, input logic [2:0] sz, input logic [31:0] wd);
      int n;
      int base;
      logic [31:0] cur;
      n    = (sz >= 3'd2) ? 4 : (1 << sz);
      base = (int'(a[1:0]) / n) * n;
      cur  = model_read(a);
      for (int b = 0; b < 4; b++)
         if (b >= base && b < base + n) cur[b*8 +: 8] = wd[b*8 +: 8];
      case (a[4:2])
         3'd1: m_led  = cur[15:0];
         3'd2: m_rgb  = cur[5:0];
         3'd3: m_segv = cur;
         3'd4: m_segc = cur[15:0];
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      m_led  = 16'd0;
      m_rgb  = 6'd0;
      m_segv = 32'd0;
      m_segc = 16'h00FF;
   endfunction

   task automatic idle_bus();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
   endtask

   // One complete transfer: address phase, then data phase sampled mid-cycle
   task automatic xfer(input bit w, input logic [4:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd);
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz;
      haddr = {27'($urandom), a};
      @(negedge clk);
      rd = hrdata;
      idle_bus();
      hwdata = wd;
      if (w) model_write(a, sz, wd);
   endtask

   // Pins against the scan model: digit shown after edge k is ((k-1)/RDIV) mod 8
   task automatic disp_check(input string name);
      int          idx;
      logic [7:0]  e_en;
      logic [7:0]  e_seg;
      logic [7:0]  dpe;
      idx   = ((int'(mcyc) - 1) / RDIV) % 8;
      dpe   = m_segc[15:8];
      e_en  = ~((8'd1 << idx) & m_segc[7:0]);
      e_seg = {~dpe[idx], hex_tab[m_segv[idx*4 +: 4]]};
      chk({name, "_en"}, {24'd0, en7}, {24'd0, e_en});
      chk({name, "_seg"}, {16'd0, d7}, {16'd0, e_seg, e_seg});
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a0;
      logic [31:0] b0;
      checks = 0;
      errors = 0;
      hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      model_reset();
      rst = 1'b1; hready = 1'b1; hwdata = 32'd0; haddr = 32'd0; sw = 16'hA5A5;
      idle_bus();

      // Reset state and first scan output
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_en", {24'd0, en7}, 32'h000000FF);
      chk("rst_d7", {16'd0, d7}, 32'h0000FFFF);
      chk("rst_hrdata", hrdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_led", {16'd0, led}, 32'd0);
      chk("rel_rgb", {26'd0, rgb}, 32'd0);
      chk("rel_en", {24'd0, en7}, 32'h000000FE);
      chk("rel_d7", {16'd0, d7}, 32'h0000C0C0);
      chk("hreadyout", {31'd0, hreadyout}, 32'd1);
      chk("hresp", {31'd0, hresp}, 32'd0);

      // Register map / byte lane vectors
      tbl.push_back('{1'b0, 5'h10, 3'd2, 32'h0,        32'h000000FF});
      tbl.push_back('{1'b1, 5'h0C, 3'd2, 32'h12345678, 32'h0});
      tbl.push_back('{1'b1, 5'h0D, 3'd0, 32'hABABABAB, 32'h0});
      tbl.push_back('{1'b0, 5'h0C, 3'd2, 32'h0,        32'h1234AB78});
      tbl.push_back('{1'b1, 5'h06, 3'd1, 32'hBEEFBEEF, 32'h0});
      tbl.push_back('{1'b0, 5'h04, 3'd2, 32'h0,        32'h00000000});
      tbl.push_back('{1'b1, 5'h04, 3'd1, 32'hBEEFBEEF, 32'h0});
      tbl.push_back('{1'b0, 5'h04, 3'd2, 32'h0,        32'h0000BEEF});
      tbl.push_back('{1'b1, 5'h08, 3'd2, 32'hFFFFFFFF, 32'h0});
      tbl.push_back('{1'b0, 5'h08, 3'd2, 32'h0,        32'h0000003F});
      tbl.push_back('{1'b1, 5'h00, 3'd2, 32'hFFFFFFFF, 32'h0});
      tbl.push_back('{1'b0, 5'h00, 3'd2, 32'h0,        32'h0000A5A5});
      tbl.push_back('{1'b1, 5'h18, 3'd2, 32'hFFFFFFFF, 32'h0});
      tbl.push_back('{1'b0, 5'h18, 3'd2, 32'h0,        32'h00000000});
      tbl.push_back('{1'b0, 5'h1C, 3'd2, 32'h0,        32'h00000000});
      tbl.push_back('{1'b1, 5'h11, 3'd0, 32'h5A5A5A5A, 32'h0});
      tbl.push_back('{1'b0, 5'h10, 3'd2, 32'h0,        32'h00005AFF});
      tbl.push_back('{1'b1, 5'h0E, 3'd1, 32'hCAFECAFE, 32'h0});
      tbl.push_back('{1'b0, 5'h0C, 3'd2, 32'h0,        32'hCAFEAB78});
      tbl.push_back('{1'b1, 5'h14, 3'd2, 32'hFFFFFFFF, 32'h0});
      foreach (tbl[i]) begin
         xfer(tbl[i].wr, tbl[i].addr, tbl[i].sz, tbl[i].wd, rd);
         if (!tbl[i].wr) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
      end
      @(negedge clk);
      chk("led_pin", {16'd0, led}, 32'h0000BEEF);
      chk("rgb_pin", {26'd0, rgb}, 32'h0000003F);

      // Back-to-back write then read of LED
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4; hsize = 3'd2;
      @(negedge clk);
      hwrite = 1'b0; hwdata = 32'h15;
      model_write(5'h04, 3'd2, 32'h15);
      @(negedge clk);
      chk("b2b_rd", hrdata, 32'h00000015);
      chk("b2b_ready", {31'd0, hreadyout}, 32'd1);
      idle_bus(); hwdata = 32'd0;

      // Pipelined CYCLES reads
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h14; hsize = 3'd2;
      @(negedge clk);
      a0 = hrdata;
      chk("cyc_abs", a0, mcyc);
      @(negedge clk);
      b0 = hrdata;
      idle_bus();
      chk("cyc_delta", b0 - a0, 32'd1);

      // Switch synchroniser latency
      sw = 16'h5A5A;
      xfer(1'b0, 5'h00, 3'd2, 32'd0, rd);
      chk("sw_latency", rd, 32'h00005A5A);

      // Display scan with digit 0 = F and its decimal point on
      xfer(1'b1, 5'h0C, 3'd2, 32'h0000000F, rd);
      xfer(1'b1, 5'h10, 3'd2, 32'h000001FF, rd);
      repeat (2) @(negedge clk);
      for (int c = 0; c < 8 * RDIV + 4; c++) begin
         disp_check($sformatf("scan%0d", c));
         if (en7 == 8'hFE) chk("dig0_seg", {24'd0, d7[7:0]}, 32'h0000000E);
         @(negedge clk);
      end
      xfer(1'b1, 5'h10, 3'd2, 32'h00000000, rd);
      repeat (2) @(negedge clk);
      for (int c = 0; c < 2 * RDIV + 1; c++) begin
         chk($sformatf("blank%0d", c), {24'd0, en7}, 32'h000000FF);
         @(negedge clk);
      end

      // Reset during a pending write data phase
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4; hsize = 3'd2;
      @(negedge clk);
      idle_bus(); hwdata = 32'h7777; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rstw_led", {16'd0, led}, 32'd0);
      xfer(1'b0, 5'h04, 3'd2, 32'd0, rd);
      chk("rstw_rd", rd, 32'd0);

      // Randomised traffic against the model
      sw = 16'($urandom);
      repeat (3) @(negedge clk);
      for (int it = 0; it < 300; it++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            int v;
            v = $urandom_range(0, 2);
            @(negedge clk);
            hwrite = 1'b1; hsize = 3'd2; haddr = $urandom;
            if (v == 0) begin hsel = 1'b0; htrans = 2'b10; end
            else if (v == 1) begin hsel = 1'b1; htrans = 2'($urandom_range(0, 1)); end
            else begin hsel = 1'b1; htrans = 2'b10; hready = 1'b0; end
            @(negedge clk);
            idle_bus(); hready = 1'b1; hwdata = $urandom;
            chk("noacc_rd", hrdata, 32'd0);
         end else begin
            logic [2:0] sz;
            logic [1:0] lo;
            logic [4:0] a;
            bit         w;
            sz = 3'($urandom_range(0, 2));
            lo = 2'($urandom) & ~2'((1 << sz) - 1);
            a  = {3'($urandom_range(0, 7)), lo};
            w  = 1'($urandom);
            xfer(w, a, sz, $urandom, rd);
            if (!w) chk($sformatf("rnd_rd@%h", a), rd, model_read(a));
            else begin
               @(negedge clk);
               chk("rnd_led", {16'd0, led}, {16'd0, m_led});
               chk("rnd_rgb", {26'd0, rgb}, {26'd0, m_rgb});
            end
         end
      end
      for (int r = 0; r < 8; r++) begin
         xfer(1'b0, 5'(r * 4), 3'd2, 32'd0, rd);
         chk($sformatf("final%0d", r), rd, model_read(5'(r * 4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
